// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared widths and state encoding for the sequential multiplier
package seq_multiplier_pkg;

  // Operand width shared with the display path (product is twice this wide)
  localparam int MULT_WIDTH = 8;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] MULT_ENC   = 2'd1;
  localparam logic [1:0] FINISH_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = IDLE_ENC,
    MULT   = MULT_ENC,
    FINISH = FINISH_ENC
  } state_t;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - modulo iteration counter with synchronous clear and terminal-count flag
module counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [WIDTH-1:0] count;

  // Terminal count: the current enabled cycle is the last one of the modulus
  assign done = en && (count == WIDTH'(MOD - 1));

  // Count enabled cycles, wrapping at the modulus; clear wins over enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - signed NxN shift-add multiplier with held, registered product
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = MULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N) + 1;

  state_t         state;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic           neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           accept;
  logic           cnt_en;
  logic           cnt_done;

  // Unsigned magnitudes; -2^(N-1) maps to 2^(N-1), which still fits N bits
  always_comb begin
    a_mag = a[N-1] ? (~a + 1'b1) : a;
    b_mag = b[N-1] ? (~b + 1'b1) : b;
  end

  assign accept = (state == IDLE) && start;
  assign cnt_en = (state == MULT);

  counter #(
    .WIDTH (CW),
    .MOD   (N)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  // Control FSM and datapath: latch on accept, N add/shift steps, then sign-fix the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= a[N-1] ^ b[N-1];
            busy   <= 1'b1;
            state  <= MULT;
          end
        end
        MULT: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt_done) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          // A zero magnitude negates back to zero, so no negative zero appears
          product <= neg ? (~acc + 1'b1) : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier with random and directed operands
module tb_seq_multiplier;

  localparam int N       = 8;
  localparam int LATENCY = N + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [15:0]   product;
  logic          busy;
  logic          done;

  int checks;
  int errors;
  int cyc;
  int busy_run;
  logic [15:0] prev_prod;

  logic [15:0] exp_q[$];
  int          acc_q[$];

  seq_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain signed integer multiply truncated to the product width
  function automatic logic [15:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    int sx;
    int sy;
    int p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    p  = sx * sy;
    return p[15:0];
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks result, latency and busy shape
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run = busy_run + 1;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [15:0] e;
          int          k;
          e = exp_q.pop_front();
          k = acc_q.pop_front();
          check("product", int'(product), int'(e));
          check("latency", cyc - k, LATENCY);
          check("busy_low_at_done", int'(busy), 0);
          check("busy_cycles", busy_run, N + 1);
        end
        busy_run = 0;
      end else if (product !== prev_prod) begin
        check("product_held", int'(product), int'(prev_prod));
      end
    end
    prev_prod = product;
  end

  // Waits (bounded) for IDLE, then pulses start for one cycle; call at a negedge
  task automatic issue(input logic [N-1:0] xa, input logic [N-1:0] xb);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t = t + 1;
    end
    if (t >= 100) check("idle_timeout", 1, 0);
    a     = xa;
    b     = xb;
    start = 1'b1;
    exp_q.push_back(ref_mul(xa, xb));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t = t + 1;
    end
    if (t >= 200) check("drain_timeout", int'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    busy_run  = 0;
    prev_prod = '0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("reset_product", int'(product), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed operands, including magnitude corners and zero
    issue(8'd7, 8'd6);
    drain();
    issue(8'hFD, 8'd5);
    drain();
    issue(8'h80, 8'h80);
    drain();
    issue(8'h80, 8'h7F);
    drain();
    issue(8'h00, 8'hFB);
    drain();

    // Start pulses and operand changes while busy must be ignored
    issue(8'd7, 8'd6);
    @(negedge clk);
    a = 8'd100; b = 8'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hC3; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: issue() fires during the done cycle of the previous op
    issue(8'd12, 8'hF6);
    issue(8'h81, 8'h81);
    issue(8'd1, 8'h80);
    drain();

    // Random operands with random idle gaps (gap 0 exercises back-to-back)
    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      int           gap;
      ra  = N'($urandom);
      rb  = N'($urandom);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      issue(ra, rb);
    end
    drain();

    // Reset mid-operation clears everything at once and suppresses done
    issue(8'd9, 8'd9);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_product", int'(product), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    void'(exp_q.pop_front());
    void'(acc_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_product", int'(product), 0);
    issue(8'd2, 8'd3);
    drain();
    check("final_product", int'(product), 16'h0006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
